// File: rtl/ber_pkg.sv
// ---------------------------------------------------------------------------
// ber_pkg
// Definitions shared by the BER measurement block and the BER mask generator:
//   - ber_state_e     : measurement FSM states
//   - BerDrainCycles  : cycles spent draining the pipeline after the last beat
//   - Ber*Width       : default data / accumulator / window widths
// ---------------------------------------------------------------------------
package ber_pkg;

  typedef enum logic [1:0] {
    BER_IDLE    = 2'd0,
    BER_MEASURE = 2'd1,
    BER_DRAIN   = 2'd2,
    BER_DONE    = 2'd3
  } ber_state_e;

  // Stage 2 and stage 3 still hold work after the last accepted beat.
  localparam int unsigned BerDrainCycles = 2;

  localparam int unsigned BerDataWidth   = 64;
  localparam int unsigned BerCntWidth    = 48;
  localparam int unsigned BerWinWidth    = 32;

endpackage

// File: rtl/ber_monitor_popcount.sv
// ---------------------------------------------------------------------------
// popcount
// Combinational population count of a DataWidth-bit word.
// Ports:
//   data_i  [DataWidth-1:0]       word to count
//   count_o [$clog2(DataWidth):0] number of set bits (0..DataWidth)
// ---------------------------------------------------------------------------
module popcount
  import ber_pkg::*;
#(
  parameter int unsigned DataWidth = BerDataWidth
) (
  input  logic [DataWidth-1:0]       data_i,
  output logic [$clog2(DataWidth):0] count_o
);

  localparam int unsigned PcWidth = $clog2(DataWidth) + 1;

  // Ripple sum of all bits; the count width holds DataWidth itself.
  always_comb begin
    count_o = '0;
    for (int unsigned i = 0; i < DataWidth; i++) begin
      count_o = count_o + PcWidth'(data_i[i]);
    end
  end

endmodule

// File: rtl/ber_monitor.sv
// ---------------------------------------------------------------------------
// ber_monitor
// Measures bit errors between observed and golden data over a programmed
// window of accepted words. Three-stage pipeline:
//   stage 1: diff = data ^ golden, stage 2: popcount(diff), stage 3: stats.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   start_i, abort_i         control (abort has highest priority)
//   window_i [WinWidth]      words to measure, latched on an accepted start
//   valid_i / ready_o        beat handshake (ready only in MEASURE)
//   data_i, golden_i         observed and expected words
//   busy_o                   MEASURE or DRAIN
//   done_o                   level, held in DONE
//   err_bits_o [CntWidth]    total flipped bits, saturating
//   err_words_o, words_o     words with flips / words accumulated
//   max_err_o                worst per-word flip count
// ---------------------------------------------------------------------------
module ber_monitor
  import ber_pkg::*;
#(
  parameter int unsigned DataWidth = BerDataWidth,
  parameter int unsigned CntWidth  = BerCntWidth,
  parameter int unsigned WinWidth  = BerWinWidth
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic [WinWidth-1:0]        window_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [DataWidth-1:0]       data_i,
  input  logic [DataWidth-1:0]       golden_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [CntWidth-1:0]        err_bits_o,
  output logic [WinWidth-1:0]        err_words_o,
  output logic [WinWidth-1:0]        words_o,
  output logic [$clog2(DataWidth):0] max_err_o
);

  localparam int unsigned PcWidth   = $clog2(DataWidth) + 1;
  localparam logic [1:0]  DrainLast = 2'(BerDrainCycles - 1);

  ber_state_e            state_q, state_d;
  logic [WinWidth-1:0]   window_q, window_d;
  logic [WinWidth-1:0]   acc_cnt_q, acc_cnt_d;
  logic [1:0]            drain_cnt_q, drain_cnt_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  s1_valid_q, s1_valid_d;
  logic [DataWidth-1:0]  s1_diff_q, s1_diff_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [PcWidth-1:0]    s2_pc_q, s2_pc_d;
  logic [PcWidth-1:0]    pc_s;

  logic [CntWidth-1:0]   err_bits_q, err_bits_d;
  logic [WinWidth-1:0]   err_words_q, err_words_d;
  logic [WinWidth-1:0]   words_q, words_d;
  logic [PcWidth-1:0]    max_err_q, max_err_d;

  logic                  accept_s;
  logic                  clear_s;
  logic [WinWidth-1:0]   acc_next_s;
  logic [CntWidth:0]     bits_sum_s;

  assign accept_s   = valid_i & ready_q;
  assign acc_next_s = acc_cnt_q + WinWidth'(1'b1);

  // Control FSM: start/abort handling, window tracking and drain timing.
  always_comb begin
    state_d     = state_q;
    window_d    = window_q;
    acc_cnt_d   = acc_cnt_q;
    drain_cnt_d = drain_cnt_q;
    clear_s     = 1'b0;
    if (abort_i) begin
      state_d = BER_IDLE;
    end else begin
      case (state_q)
        BER_IDLE, BER_DONE: begin
          if (start_i) begin
            window_d  = window_i;
            acc_cnt_d = '0;
            clear_s   = 1'b1;
            state_d   = (window_i == '0) ? BER_DONE : BER_MEASURE;
          end else begin
            state_d = state_q;
          end
        end
        BER_MEASURE: begin
          if (accept_s) begin
            acc_cnt_d = acc_next_s;
            // Leaving MEASURE on the beat that completes the window drops
            // ready in the very next cycle, so no surplus beat gets in.
            if (acc_next_s == window_q) begin
              state_d     = BER_DRAIN;
              drain_cnt_d = 2'd0;
            end else begin
              state_d = BER_MEASURE;
            end
          end else begin
            state_d = BER_MEASURE;
          end
        end
        BER_DRAIN: begin
          if (drain_cnt_q == DrainLast) begin
            state_d = BER_DONE;
          end else begin
            drain_cnt_d = drain_cnt_q + 2'd1;
          end
        end
        default: begin
          state_d = BER_IDLE;
        end
      endcase
    end
  end

  // Status outputs are decoded from the next state so they leave a flop.
  always_comb begin
    ready_d = (state_d == BER_MEASURE);
    busy_d  = (state_d == BER_MEASURE) || (state_d == BER_DRAIN);
    done_d  = (state_d == BER_DONE);
  end

  // Pipeline stages 1 and 2; abort squashes any beat in flight.
  always_comb begin
    s1_valid_d = accept_s & ~abort_i;
    if (accept_s) begin
      s1_diff_d = data_i ^ golden_i;
    end else begin
      s1_diff_d = s1_diff_q;
    end
    s2_valid_d = s1_valid_q & ~abort_i;
    if (s1_valid_q) begin
      s2_pc_d = pc_s;
    end else begin
      s2_pc_d = s2_pc_q;
    end
  end

  popcount #(
    .DataWidth(DataWidth)
  ) u_popcount (
    .data_i (s1_diff_q),
    .count_o(pc_s)
  );

  // One extra bit catches the carry used for saturation.
  assign bits_sum_s = {1'b0, err_bits_q} + (CntWidth + 1)'(s2_pc_q);

  // Stage 3: statistics; abort freezes partial results, start clears them.
  always_comb begin
    err_bits_d  = err_bits_q;
    err_words_d = err_words_q;
    words_d     = words_q;
    max_err_d   = max_err_q;
    if (abort_i) begin
      err_bits_d = err_bits_q;
    end else if (clear_s) begin
      err_bits_d  = '0;
      err_words_d = '0;
      words_d     = '0;
      max_err_d   = '0;
    end else if (s2_valid_q) begin
      if (bits_sum_s[CntWidth]) begin
        err_bits_d = '1;
      end else begin
        err_bits_d = bits_sum_s[CntWidth-1:0];
      end
      words_d = words_q + WinWidth'(1'b1);
      if (s2_pc_q != '0) begin
        err_words_d = err_words_q + WinWidth'(1'b1);
      end else begin
        err_words_d = err_words_q;
      end
      if (s2_pc_q > max_err_q) begin
        max_err_d = s2_pc_q;
      end else begin
        max_err_d = max_err_q;
      end
    end else begin
      err_bits_d = err_bits_q;
    end
  end

  // State, pipeline and statistic registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= BER_IDLE;
      window_q    <= '0;
      acc_cnt_q   <= '0;
      drain_cnt_q <= 2'd0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_diff_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_pc_q     <= '0;
      err_bits_q  <= '0;
      err_words_q <= '0;
      words_q     <= '0;
      max_err_q   <= '0;
    end else begin
      state_q     <= state_d;
      window_q    <= window_d;
      acc_cnt_q   <= acc_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      s1_valid_q  <= s1_valid_d;
      s1_diff_q   <= s1_diff_d;
      s2_valid_q  <= s2_valid_d;
      s2_pc_q     <= s2_pc_d;
      err_bits_q  <= err_bits_d;
      err_words_q <= err_words_d;
      words_q     <= words_d;
      max_err_q   <= max_err_d;
    end
  end

  assign ready_o     = ready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_bits_o  = err_bits_q;
  assign err_words_o = err_words_q;
  assign words_o     = words_q;
  assign max_err_o   = max_err_q;

endmodule

// File: doc/ber_monitor.md
Name: ber_monitor

Overview:
- Receive-side counterpart of the cache-path BER mask generator: measures the bit errors actually present in data read back after fault injection.
- Each accepted beat supplies observed data and golden reference data. The block XORs them, popcounts the difference and accumulates statistics over a programmed window of words.
- Sits beside the cache subsystem as a measurement engine, driven by a simple start/abort/done control interface.

Parameters:
- DataWidth, 64, width of the observed and golden words.
- CntWidth, 48, width of the error-bit accumulator; saturating.
- WinWidth, 32, width of the window word count and the words counters.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  begin measurement; sampled only in IDLE or DONE.
- abort_i  in  1  cancel measurement from any state.
- window_i  in  WinWidth  number of words to measure; latched on an accepted start.
- valid_i  in  1  data beat valid.
- ready_o  out  1  beat accepted when valid_i && ready_o.
- data_i  in  DataWidth  observed (possibly corrupted) word.
- golden_i  in  DataWidth  expected word.
- busy_o  out  1  high in MEASURE or DRAIN.
- done_o  out  1  high (level) in DONE.
- err_bits_o  out  CntWidth  total flipped bits.
- err_words_o  out  WinWidth  words with at least one flipped bit.
- words_o  out  WinWidth  words accumulated.
- max_err_o  out  $clog2(DataWidth)+1  worst per-word flip count seen.

Behaviour:
- Reset value is 0 for every output and every pipeline register; the FSM resets to IDLE.
- FSM states are IDLE, MEASURE, DRAIN, DONE.
- IDLE/DONE on start_i:
  - Latch window_i and zero all four statistics counters.
  - Go to MEASURE.
  - If window_i == 0, go to DONE instead; counters stay 0.
- MEASURE:
  - ready_o = 1.
  - Each handshake increments an accepted-word counter (internal, not words_o).
  - When the handshake accepts word number window, go to DRAIN on the next cycle.
  - ready_o drops in that same next cycle, so no extra beat is ever accepted.
- DRAIN: stay exactly 2 cycles, then go to DONE.
- DONE: results are held stable; done_o = 1 until start_i or abort_i.
- Outside MEASURE:
  - ready_o = 0.
  - valid_i is ignored.
  - data_i and golden_i are don't-care.
- Pipeline, for a beat accepted in cycle t:
  - Stage 1 registers diff = data_i ^ golden_i plus a valid bit; visible at t+1.
  - Stage 2 registers popcount(diff); visible at t+2.
  - Stage 3 updates the counters; visible at t+3.
  - Therefore DONE is entered with final counters in the same cycle the last contribution is visible.
- Stage 3 arithmetic:
  - err_bits += pc, saturating at all-ones.
  - words += 1.
  - err_words += 1 when pc != 0.
  - max_err = max(max_err, pc).
  - Width of pc is $clog2(DataWidth)+1, zero-extended into the accumulator.
- abort_i:
  - Highest priority.
  - Next state is IDLE and pipeline valid bits are cleared.
  - Counters keep their partial values.
- start_i and abort_i in the same cycle: abort wins; the state ends in IDLE.
- start_i in MEASURE or DRAIN is ignored.
- Back-to-back beats (valid_i held high) are accepted every cycle, with no bubbles.
- Reset asserted mid-measurement clears everything asynchronously; there is no residual counting after release.

Decomposition:
- Shared package ber_pkg holds:
  - the ber_state_e enum (IDLE, MEASURE, DRAIN, DONE);
  - the DRAIN length constant BerDrainCycles = 2;
  - default widths shared with the BER mask generator (BerDataWidth = 64).
- Sub-module popcount (combinational, DataWidth in, $clog2(DataWidth)+1 out), instantiated between stage 1 and stage 2.

Test Plan:
- Clean window: start with window=4; 4 beats with data==golden, back-to-back. Required:
  - done_o rises 3 cycles after the last beat;
  - err_bits=0, err_words=0, words=4, max_err=0.
- Known flips: window=3 with diffs 64'h1, 64'hFF, 64'hFFFF_FFFF_FFFF_FFFF. Required: err_bits=73, err_words=3, max_err=64, words=3.
- Gapped valid: window=2, beats separated by 5 idle cycles, each diff 64'h3. Required:
  - err_bits=4;
  - ready_o is 0 in the cycle after the 2nd beat, and an extra valid beat there is not counted.
- window=0: a start gives done_o one cycle later with all counters 0 and no beat accepted.
- Abort: window=10; abort_i after 4 beats (diff 64'h1 each), with start_i asserted in the same cycle. Required:
  - IDLE next cycle, busy_o=0, done_o never asserted;
  - err_bits ends at ≤4 and never changes afterwards.
- Saturation/reset: force err_bits near max (CntWidth=8 build), feed diffs of 64 bits each. Required:
  - err_bits sticks at 255;
  - rst_ni low mid-MEASURE zeroes all outputs immediately, asynchronously.
